// File: rtl/print_arbiter_if.sv
// Requester/display bundle for print_arbiter: requesters drive req/req_value,
// the arbiter returns ack and drives the display decoder side.
interface print_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int VALUE_W = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0][VALUE_W-1:0] req_value;
    logic [NUM_REQ-1:0]              ack;
    logic [VALUE_W-1:0]              disp_value;
    logic                            disp_valid;
    logic [ID_W-1:0]                 grant_id;
    logic                            busy;

    modport master (
        output req, req_value,
        input  ack, disp_value, disp_valid, grant_id, busy
    );

    modport slave (
        input  req, req_value,
        output ack, disp_value, disp_valid, grant_id, busy
    );
endinterface

// File: rtl/print_arbiter.sv
// Round-robin arbiter sharing the hex display between print requesters, with a
// minimum dwell per value. Define PRINT_ARB_BLANK_EN to blank the display once dwell expires idle.
module print_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int VALUE_W     = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic            clock,
    input  logic            reset,
    print_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DWELL, SHOWN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               valid_q, valid_d;
    logic [PTR_W-1:0]   gid_q, gid_d;
    logic [NUM_REQ-1:0] ack_d;
    logic               busy_d;
    logic               gw;
    logic               hit;
    logic [PTR_W-1:0]   pick;
    int                 rr_idx;

    // First active requester at or after ptr, wrapping.
    always_comb begin
        hit    = 1'b0;
        pick   = '0;
        rr_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!hit && bus.req[rr_idx]) begin
                hit  = 1'b1;
                pick = PTR_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        value_d = value_q;
        valid_d = valid_q;
        gid_d   = gid_q;
        ack_d   = '0;
        busy_d  = 1'b0;
        gw      = (state_q == IDLE) || (state_q == SHOWN) ||
                  (state_q == DWELL && cnt_q == '0);
        if (!gw) begin
            busy_d = 1'b1;
            cnt_d  = cnt_q - CNT_W'(1);
        end else if (hit) begin
            ack_d   = NUM_REQ'(1) << pick;
            value_d = bus.req_value[pick];
            valid_d = 1'b1;
            gid_d   = pick;
            ptr_d   = (int'(pick) == NUM_REQ - 1) ? '0 : pick + PTR_W'(1);
            state_d = DWELL;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else if (state_q == DWELL) begin
            state_d = SHOWN;
`ifdef PRINT_ARB_BLANK_EN
            valid_d = 1'b0;
`else
            valid_d = valid_q;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            value_q <= value_d;
            valid_q <= valid_d;
            gid_q   <= gid_d;
        end
    end

    // Grant must not leak out while reset is discarding the dwell.
    assign bus.ack        = reset ? '0 : ack_d;
    assign bus.busy       = busy_d;
    assign bus.disp_value = value_q;
    assign bus.disp_valid = valid_q;
    assign bus.grant_id   = gid_q;
endmodule

// File: tb/tb_print_arbiter.sv
// Bench for print_arbiter: directed scenarios plus random traffic on a
// HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance against a cycle-count model.
module tb_print_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef PRINT_ARB_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    print_arbiter_if #(.NUM_REQ(2), .VALUE_W(32)) ifa ();
    print_arbiter_if #(.NUM_REQ(2), .VALUE_W(32)) ifb ();

    print_arbiter #(.NUM_REQ(2), .VALUE_W(32), .HOLD_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa.slave));
    print_arbiter #(.NUM_REQ(2), .VALUE_W(32), .HOLD_CYCLES(1)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb.slave));

    always #5 clock = ~clock;

    // Model: "since" = cycles elapsed since the last grant cycle (saturating).
    typedef struct {
        int          ptr;
        bit          granted;
        int          since;
        logic [31:0] val;
        bit          vld;
        int          gid;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ptr = 0; m.granted = 0; m.since = 0; m.val = '0; m.vld = 0; m.gid = 0;
        return m;
    endfunction

    function automatic int mdl_pick(mdl_t m, logic [1:0] r, int hold);
        if (m.granted && m.since < hold) return -1;
        for (int k = 0; k < 2; k++)
            if (r[(m.ptr + k) % 2]) return (m.ptr + k) % 2;
        return -1;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic [1:0] r, logic [1:0][31:0] v,
                                      int hold, bit rst);
        mdl_t n;
        int   g;
        if (rst) return mdl_reset();
        n = m;
        g = mdl_pick(m, r, hold);
        if (g >= 0) begin
            n.val = v[g]; n.vld = 1; n.gid = g; n.ptr = (g + 1) % 2;
            n.granted = 1; n.since = 1;
        end else begin
            if (m.granted && m.since >= hold && BLANK) n.vld = 0;
            if (m.since <= hold) n.since = m.since + 1;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ifa.req = '0; ifb.req = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifa.req = 2'b11; ifa.req_value[0] = 32'h11; ifa.req_value[1] = 32'h22;
        ifb.req = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clock);
            n_chk++;
            if (ifa.ack !== 2'b00 || ifa.disp_valid !== 1'b0 ||
                ifa.disp_value !== 32'h0 || ifa.grant_id !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state c%0d ack=%b vld=%b val=%h gid=%b exp 00/0/0/0",
                         c, ifa.ack, ifa.disp_valid, ifa.disp_value, ifa.grant_id);
            end
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (ifa.ack !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant got=%b exp=01", ifa.ack);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        ifa.req_value[0] = 32'h1234; ifa.req = 2'b01;
        @(negedge clock);
        n_chk++;
        if (ifa.ack !== 2'b01) begin n_fail++; $display("FAIL seq_ack0 got=%b exp=01", ifa.ack); end
        tick();
        ifa.req_value[1] = 32'h0055; ifa.req = 2'b10;
        @(negedge clock);
        n_chk++;
        if (ifa.disp_value !== 32'h1234 || ifa.disp_valid !== 1'b1 || ifa.grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_disp0 val=%h vld=%b gid=%b exp 1234/1/0",
                     ifa.disp_value, ifa.disp_valid, ifa.grant_id);
        end
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin tick(); @(negedge clock); end
            n_chk++;
            if (ifa.busy !== 1'b1 || ifa.ack !== 2'b00) begin
                n_fail++;
                $display("FAIL seq_busy c%0d busy=%b ack=%b exp 1/00", c, ifa.busy, ifa.ack);
            end
        end
        tick();
        @(negedge clock);
        n_chk++;
        if (ifa.ack !== 2'b10 || ifa.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_ack1 ack=%b busy=%b exp 10/0", ifa.ack, ifa.busy);
        end
        tick();
        ifa.req = '0;
        @(negedge clock);
        n_chk++;
        if (ifa.disp_value !== 32'h0055 || ifa.grant_id !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_disp1 val=%h gid=%b exp 00000055/1", ifa.disp_value, ifa.grant_id);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp;
        do_reset();
        ifa.req = 2'b11; ifa.req_value[0] = 32'hA0; ifa.req_value[1] = 32'hA1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clock);
            exp = (c % 4 != 0) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
            n_chk++;
            if (ifa.ack !== exp) begin
                n_fail++;
                $display("FAIL alt_ack c%0d got=%b exp=%b", c, ifa.ack, exp);
            end
            tick();
        end
        ifa.req = '0;
    endtask

    task automatic test_hold1();
        logic [1:0]  exp;
        logic [31:0] ev;
        do_reset();
        ifb.req = 2'b11; ifb.req_value[0] = 32'hB0; ifb.req_value[1] = 32'hB1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            exp = (c % 2 == 0) ? 2'b01 : 2'b10;
            ev  = ((c - 1) % 2 == 0) ? 32'hB0 : 32'hB1;
            n_chk++;
            if (ifb.ack !== exp || ifb.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL h1_ack c%0d ack=%b busy=%b exp %b/0", c, ifb.ack, ifb.busy, exp);
            end
            if (c > 0) begin
                n_chk++;
                if (ifb.disp_value !== ev || ifb.disp_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL h1_disp c%0d val=%h vld=%b exp %h/1", c,
                             ifb.disp_value, ifb.disp_valid, ev);
                end
            end
            tick();
        end
        ifb.req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ifa.req_value[0] = 32'h77; ifa.req = 2'b01;
        @(negedge clock);
        n_chk++;
        if (ifa.ack !== 2'b01) begin n_fail++; $display("FAIL rmid_ack0 got=%b exp=01", ifa.ack); end
        tick();
        ifa.req_value[1] = 32'h88; ifa.req = 2'b10;
        tick();
        reset = 1'b1; ifa.req = 2'b11;
        @(negedge clock);
        n_chk++;
        if (ifa.ack !== 2'b00) begin n_fail++; $display("FAIL rmid_ack_in_rst got=%b exp=00", ifa.ack); end
        tick();
        @(negedge clock);
        n_chk++;
        if (ifa.disp_valid !== 1'b0 || ifa.grant_id !== 1'b0 || ifa.disp_value !== 32'h0 ||
            ifa.ack !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_outs vld=%b gid=%b val=%h ack=%b exp 0/0/0/00",
                     ifa.disp_valid, ifa.grant_id, ifa.disp_value, ifa.ack);
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (ifa.ack !== 2'b01) begin n_fail++; $display("FAIL rmid_prio got=%b exp=01", ifa.ack); end
        tick();
        ifa.req = '0;
    endtask

    task automatic test_blank();
        bit ev;
        do_reset();
        ifa.req_value[0] = 32'h00AB; ifa.req = 2'b01;
        @(negedge clock);
        n_chk++;
        if (ifa.ack !== 2'b01) begin n_fail++; $display("FAIL blank_ack got=%b exp=01", ifa.ack); end
        tick();
        ifa.req = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            ev = (c >= 5) ? !BLANK : 1'b1;
            n_chk++;
            if (ifa.disp_value !== 32'h00AB || ifa.disp_valid !== ev) begin
                n_fail++;
                $display("FAIL blank_disp c%0d val=%h vld=%b exp 000000ab/%b",
                         c, ifa.disp_value, ifa.disp_valid, ev);
            end
            tick();
        end
    endtask

    task automatic test_random();
        mdl_t       ma, mb;
        logic [1:0] ea, eb;
        int         ga, gb;
        bit         ba, bb;
        do_reset();
        ma = mdl_reset(); mb = mdl_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            ga = mdl_pick(ma, ifa.req, 4);
            gb = mdl_pick(mb, ifb.req, 1);
            ea = (reset || ga < 0) ? 2'b00 : (2'b01 << ga);
            eb = (reset || gb < 0) ? 2'b00 : (2'b01 << gb);
            ba = ma.granted && ma.since >= 1 && ma.since < 4;
            bb = 1'b0;
            n_chk++;
            if (ifa.ack !== ea || ifa.busy !== ba || ifa.disp_value !== ma.val ||
                ifa.disp_valid !== ma.vld || ifa.grant_id !== 1'(ma.gid)) begin
                n_fail++;
                $display("FAIL rnd_a c%0d ack=%b/%b busy=%b/%b val=%h/%h vld=%b/%b gid=%b/%0d (got/exp)",
                         c, ifa.ack, ea, ifa.busy, ba, ifa.disp_value, ma.val,
                         ifa.disp_valid, ma.vld, ifa.grant_id, ma.gid);
            end
            n_chk++;
            if (ifb.ack !== eb || ifb.busy !== bb || ifb.disp_value !== mb.val ||
                ifb.disp_valid !== mb.vld || ifb.grant_id !== 1'(mb.gid)) begin
                n_fail++;
                $display("FAIL rnd_b c%0d ack=%b/%b busy=%b/%b val=%h/%h vld=%b/%b gid=%b/%0d (got/exp)",
                         c, ifb.ack, eb, ifb.busy, bb, ifb.disp_value, mb.val,
                         ifb.disp_valid, mb.vld, ifb.grant_id, mb.gid);
            end
            ma = mdl_step(ma, ifa.req, ifa.req_value, 4, reset);
            mb = mdl_step(mb, ifb.req, ifb.req_value, 1, reset);
            tick();
            // Requesters: an ack consumes the value; otherwise hold, occasionally withdraw.
            for (int i = 0; i < 2; i++) begin
                if (ea[i]) ifa.req[i] = 1'b0;
                else if (ifa.req[i] && $urandom_range(0, 15) == 0) ifa.req[i] = 1'b0;
                if (!ifa.req[i] && $urandom_range(0, 2) == 0) begin
                    ifa.req[i] = 1'b1; ifa.req_value[i] = $urandom;
                end
                if (eb[i]) ifb.req[i] = 1'b0;
                else if (ifb.req[i] && $urandom_range(0, 15) == 0) ifb.req[i] = 1'b0;
                if (!ifb.req[i] && $urandom_range(0, 1) == 0) begin
                    ifb.req[i] = 1'b1; ifb.req_value[i] = $urandom;
                end
            end
            reset = ($urandom_range(0, 60) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        ifa.req = '0; ifa.req_value = '0;
        ifb.req = '0; ifb.req_value = '0;
        reset = 1'b1;
        test_reset();
        test_sequence();
        test_alternate();
        test_hold1();
        test_reset_mid();
        test_blank();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
